signal_input_conditioner: RTL and testbench

SIGNAL_INPUT_CONDITIONER -- requirements
Module: signal_input_conditioner

---
 rtl/signal_pkg.sv | 7 +
 rtl/debounce_channel.sv | 58 +++++
 rtl/signal_input_conditioner.sv | 88 ++++++++
 tb/tb_signal_input_conditioner.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/signal_pkg.sv
// Shared defaults for the signal input conditioner: debounce length and step divider.
package signal_pkg;

  localparam int DEB_CYCLES_DEF = 16;
  localparam int STEP_DIV_DEF   = 1000;

endpackage

// File: rtl/debounce_channel.sv
// One raw contact: 2-flop synchronizer followed by a consecutive-cycle debouncer.
module debounce_channel
  import signal_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic Clk,
  input  logic Rst,
  input  logic Din,
  output logic Level,
  output logic Rise
);

  localparam int CntW = $clog2(DEB_CYCLES);
  localparam logic [CntW-1:0] CntLast = CntW'(DEB_CYCLES - 1);

  logic            syncMeta_q;
  logic            syncOut_q;
  logic            level_q;
  logic            level_d;
  logic [CntW-1:0] count_q;
  logic [CntW-1:0] count_d;
  logic            commit;

  // The counter only runs while the synced input disagrees with the level;
  // on the last count the level commits and the counter restarts from zero.
  always_comb begin
    level_d = level_q;
    count_d = '0;
    commit  = 1'b0;
    if (syncOut_q != level_q) begin
      if (count_q == CntLast) begin
        commit  = 1'b1;
        level_d = syncOut_q;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      syncMeta_q <= 1'b0;
      syncOut_q  <= 1'b0;
      level_q    <= 1'b0;
      count_q    <= '0;
    end else begin
      syncMeta_q <= Din;
      syncOut_q  <= syncMeta_q;
      level_q    <= level_d;
      count_q    <= count_d;
    end
  end

  assign Level = level_q;
  assign Rise  = commit & syncOut_q;

endmodule

// File: rtl/signal_input_conditioner.sv
// Conditions the hazard button and lever contacts, latches the hazard request
// and generates the sequencer step tick.
module signal_input_conditioner
  import signal_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int STEP_DIV   = STEP_DIV_DEF
) (
  input  logic Clk,
  input  logic Rst,
  input  logic EBtn,
  input  logic LIn,
  input  logic RIn,
  output logic E,
  output logic L,
  output logic R,
  output logic Tick
);

  localparam int DivW = $clog2(STEP_DIV);
  localparam logic [DivW-1:0] DivLast = DivW'(STEP_DIV - 1);

  logic            hazardLevel;
  logic            hazardRise;
  logic            leftLevel;
  logic            rightLevel;
  logic            unusedRiseL;
  logic            unusedRiseR;
  logic            eLatch_q;
  logic            eLatch_d;
  logic [DivW-1:0] divCount_q;
  logic [DivW-1:0] divCount_d;
  logic            tick_q;
  logic            tick_d;

  debounce_channel #(.DEB_CYCLES(DEB_CYCLES)) uHazard (
    .Clk  (Clk),
    .Rst  (Rst),
    .Din  (EBtn),
    .Level(hazardLevel),
    .Rise (hazardRise)
  );

  debounce_channel #(.DEB_CYCLES(DEB_CYCLES)) uLeft (
    .Clk  (Clk),
    .Rst  (Rst),
    .Din  (LIn),
    .Level(leftLevel),
    .Rise (unusedRiseL)
  );

  debounce_channel #(.DEB_CYCLES(DEB_CYCLES)) uRight (
    .Clk  (Clk),
    .Rst  (Rst),
    .Din  (RIn),
    .Level(rightLevel),
    .Rise (unusedRiseR)
  );

  // Hazard is push-on/push-off: only the press commit flips the latch.
  always_comb begin
    eLatch_d   = eLatch_q ^ hazardRise;
    tick_d     = (divCount_q == DivLast);
    divCount_d = tick_d ? '0 : divCount_q + 1'b1;
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      eLatch_q   <= 1'b0;
      divCount_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      eLatch_q   <= eLatch_d;
      divCount_q <= divCount_d;
      tick_q     <= tick_d;
    end
  end

  assign E    = eLatch_q;
  assign L    = leftLevel;
  assign R    = rightLevel;
  assign Tick = tick_q;

  // hazardLevel is kept for visibility of the debounced button state.
  logic unusedHazardLevel;
  assign unusedHazardLevel = hazardLevel;

endmodule

// File: tb/tb_signal_input_conditioner.sv
// Directed and randomized checks of the input conditioner against a persistence-based reference model.
module tb_signal_input_conditioner;

  localparam int Deb  = 4;
  localparam int Step = 8;

  logic Clk = 1'b0;
  logic Rst = 1'b0;
  logic EBtn = 1'b0;
  logic LIn = 1'b0;
  logic RIn = 1'b0;
  logic E;
  logic L;
  logic R;
  logic Tick;

  int checks = 0;
  int errors = 0;

  // Reference model: each raw input reaches the debouncer two edges late; a level
  // follows a value once that value has persisted for Deb consecutive edges.
  bit p1[3];
  bit p2[3];
  bit lvl[3];
  bit lastD[3];
  int runLen[3];
  bit eModel;
  int edgeCount;

  signal_input_conditioner #(.DEB_CYCLES(Deb), .STEP_DIV(Step)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .EBtn(EBtn),
    .LIn (LIn),
    .RIn (RIn),
    .E   (E),
    .L   (L),
    .R   (R),
    .Tick(Tick)
  );

  always #5 Clk = ~Clk;

  task automatic checkOutput(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic l, input logic r);
    EBtn = e;
    LIn  = l;
    RIn  = r;
  endtask

  task automatic modelEdge();
    bit raw[3];
    bit d;
    raw[0] = EBtn;
    raw[1] = LIn;
    raw[2] = RIn;
    if (!Rst) begin
      for (int c = 0; c < 3; c++) begin
        p1[c] = 0; p2[c] = 0; lvl[c] = 0; lastD[c] = 0; runLen[c] = 0;
      end
      eModel = 0;
      edgeCount = 0;
    end else begin
      edgeCount++;
      for (int c = 0; c < 3; c++) begin
        d = p2[c];
        p2[c] = p1[c];
        p1[c] = raw[c];
        if (d == lastD[c]) begin
          if (runLen[c] < 1000) runLen[c]++;
        end else begin
          lastD[c] = d;
          runLen[c] = 1;
        end
        if (runLen[c] >= Deb && d != lvl[c]) begin
          if (c == 0 && d) eModel = ~eModel;
          lvl[c] = d;
        end
      end
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge Clk);
      modelEdge();
      #1;
      checkOutput("model_E", E, eModel);
      checkOutput("model_L", L, lvl[1]);
      checkOutput("model_R", R, lvl[2]);
      checkOutput("model_Tick", Tick, (edgeCount > 0) && (edgeCount % Step == 0));
    end
  endtask

  task automatic doReset();
    applyStimulus(0, 0, 0);
    Rst = 1'b0;
    runCycles(2);
    Rst = 1'b1;
  endtask

  initial begin
    int hold;
    $display("[TB] start DEB_CYCLES=%0d STEP_DIV=%0d", Deb, Step);

    // Reset with all inputs high, then tick timing after release.
    applyStimulus(1, 1, 1);
    Rst = 1'b0;
    runCycles(3);
    checkOutput("rst_E", E, 1'b0);
    checkOutput("rst_L", L, 1'b0);
    checkOutput("rst_R", R, 1'b0);
    checkOutput("rst_Tick", Tick, 1'b0);
    Rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      runCycles(1);
      checkOutput("tick_edge", Tick, (k == 8 || k == 16));
    end

    // Left debounce rise and fall latency.
    doReset();
    LIn = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      runCycles(1);
      checkOutput("left_rise", L, k >= 6);
    end
    LIn = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      runCycles(1);
      checkOutput("left_fall", L, k < 6);
    end

    // Short pulse on the right contact is rejected.
    doReset();
    RIn = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      if (k == 4) RIn = 1'b0;
      runCycles(1);
      checkOutput("right_glitch", R, 1'b0);
    end

    // Hazard push-on/push-off.
    doReset();
    EBtn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      runCycles(1);
      checkOutput("haz_on", E, k >= 6);
    end
    EBtn = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      runCycles(1);
      checkOutput("haz_release", E, 1'b1);
    end
    EBtn = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      runCycles(1);
      checkOutput("haz_off", E, k < 6);
    end
    EBtn = 1'b0;
    runCycles(10);

    // Reset in the middle of a left debounce with the hazard latched.
    EBtn = 1'b1;
    runCycles(10);
    EBtn = 1'b0;
    runCycles(10);
    checkOutput("mid_E_set", E, 1'b1);
    LIn = 1'b1;
    runCycles(4);
    Rst = 1'b0;
    runCycles(1);
    checkOutput("mid_rst_E", E, 1'b0);
    checkOutput("mid_rst_L", L, 1'b0);
    Rst = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      runCycles(1);
      checkOutput("mid_left", L, k >= 6);
      checkOutput("mid_E_hold", E, 1'b0);
    end

    // Left and right together commit on the same edge.
    doReset();
    applyStimulus(0, 1, 1);
    for (int k = 1; k <= 8; k++) begin
      runCycles(1);
      checkOutput("simul_L", L, k >= 6);
      checkOutput("simul_R", R, k >= 6);
    end

    // Randomized segments with occasional resets.
    doReset();
    for (int seg = 0; seg < 200; seg++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 39) == 0) begin
        Rst = 1'b0;
        runCycles(1);
        Rst = 1'b1;
      end
      hold = $urandom_range(1, 8);
      runCycles(hold);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
